fnn_layer_collector: RTL and testbench

Parametrised output stage for one fully-connected layer. Waits for all neurons of the layer to finish, captures their results in one cycle, and streams them out as `LANES` results per beat on a valid/ready handshake. It sits between the neuron array of layer k and the input of layer k+1 (or the result sink). It generalises the earlier fixed-10-neuron, 1-result-per-shift serializer in three ways:
- arbitrary neuron count
- multi-lane output
- real backpressure and abort

---
 rtl/fnn_layer_pkg.sv | 20 ++
 rtl/fnn_relu.sv | 14 +
 rtl/fnn_layer_collector.sv | 124 ++++++++++++
 tb/tb_fnn_layer_collector.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fnn_layer_pkg.sv
// Shared types and helpers for the fully-connected layer output stage.
package fnn_layer_pkg;

  // Neuron result width shared with the neuron block (input width + 3).
  localparam int FNN_DATA_W = 29;

  // Collector pass states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } fnn_state_e;

  // Integer ceiling division, used to size the beat count.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/fnn_relu.sv
// Combinational ReLU on one two's-complement neuron result.
module fnn_relu
  import fnn_layer_pkg::*;
#(
  parameter int DATA_W = FNN_DATA_W
) (
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  // Negative values (sign bit set) clamp to zero, others pass unchanged.
  assign dout = din[DATA_W-1] ? '0 : din;

endmodule

// File: rtl/fnn_layer_collector.sv
// Layer output collector: waits for every neuron of the layer, captures all
// results in one cycle, then streams them LANES per beat on valid/ready.
// Optional macro FNN_LAYER_RELU_EN applies ReLU to each result at capture.
//
// Handshake: a beat is transferred on a rising edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low the
// beat (out_data, out_beat, out_last) holds steady and out_valid stays high
// unless restart aborts the pass.
module fnn_layer_collector
  import fnn_layer_pkg::*;
#(
  parameter int DATA_W      = FNN_DATA_W,
  parameter int NUM_NEURONS = 10,
  parameter int LANES       = 1,
  parameter int IDX_W       = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start,
  input  logic                          restart,
  input  logic [NUM_NEURONS-1:0]        neuron_done,
  input  logic [NUM_NEURONS*DATA_W-1:0] neuron_data,
  input  logic [NUM_NEURONS-1:0]        weights_loaded,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_W-1:0]       out_data,
  output logic [IDX_W-1:0]              out_beat,
  output logic                          out_last,
  output logic                          layer_ready,
  output logic                          neurons_finished,
  output logic                          transferred,
  output logic                          busy,
  output fnn_state_e                    state_dbg
);

  localparam int BEATS = ceil_div(NUM_NEURONS, LANES);
  localparam int PAD_W = BEATS * LANES * DATA_W;

  fnn_state_e                    state_q, state_d;
  logic [NUM_NEURONS*DATA_W-1:0] hold_q;
  logic [NUM_NEURONS*DATA_W-1:0] capture_data;
  logic [PAD_W-1:0]              hold_pad;
  logic [IDX_W-1:0]              beat_q;
  logic                          all_done;
  logic                          accept;
  logic                          last_beat;
  logic                          capture;

`ifdef FNN_LAYER_RELU_EN
  for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_relu
    fnn_relu #(.DATA_W(DATA_W)) u_relu (
      .din  (neuron_data[i*DATA_W +: DATA_W]),
      .dout (capture_data[i*DATA_W +: DATA_W])
    );
  end
`else
  assign capture_data = neuron_data;
`endif

  assign all_done  = &neuron_done;
  assign out_valid = (state_q == SHIFT);
  assign last_beat = (beat_q == IDX_W'(BEATS - 1));
  assign accept    = out_valid && out_ready;
  assign capture   = (state_q == WAIT) && !restart && all_done;

  assign out_last         = out_valid && last_beat;
  assign out_beat         = out_valid ? beat_q : '0;
  assign neurons_finished = (state_q == SHIFT) || (state_q == DONE);
  assign transferred      = (state_q == DONE);
  assign busy             = (state_q == WAIT) || (state_q == SHIFT);
  assign state_dbg        = state_q;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; restart has priority over every other request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!restart && start)        state_d = WAIT;
      WAIT:    if (restart)                  state_d = IDLE;
               else if (all_done)            state_d = SHIFT;
      SHIFT:   if (restart)                  state_d = IDLE;
               else if (accept && last_beat) state_d = DONE;
      DONE:    if (restart)                  state_d = IDLE;
      default:                               state_d = IDLE;
    endcase
  end

  // Capture all neuron results once, on the edge where every neuron is done.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        hold_q <= '0;
    else if (capture) hold_q <= capture_data;
  end

  // Beat counter: cleared in IDLE or on abort, advanced per accepted beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                        beat_q <= '0;
    else if (state_q == IDLE || restart) beat_q <= '0;
    else if (accept && !last_beat)    beat_q <= beat_q + 1'b1;
  end

  // Beat mux over a zero-padded copy so unused lanes on the last beat read 0.
  always_comb begin
    hold_pad = '0;
    hold_pad[NUM_NEURONS*DATA_W-1:0] = hold_q;
    out_data = '0;
    if (out_valid) begin
      for (int b = 0; b < BEATS; b++) begin
        if (beat_q == IDX_W'(b)) out_data = hold_pad[b*LANES*DATA_W +: LANES*DATA_W];
      end
    end
  end

  // Layer readiness tracks the weight-load flags with one cycle of latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) layer_ready <= 1'b0;
    else       layer_ready <= &weights_loaded;
  end

endmodule

// File: tb/tb_fnn_layer_collector.sv
// Bench for fnn_layer_collector: one instance with 1 lane, one with 3 lanes,
// sharing the neuron side; each output stream has its own scoreboard.
module tb_fnn_layer_collector;
  import fnn_layer_pkg::*;

  localparam int DW = 29;
  localparam int NN = 10;
  localparam int IW = 4;
  localparam int W1 = 1 + IW + DW;
  localparam int W3 = 1 + IW + 3 * DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic             start = 1'b0, restart = 1'b0;
  logic [NN-1:0]    neuron_done = '0, weights_loaded = '0;
  logic [NN*DW-1:0] neuron_data = '0;
  logic             ready1 = 1'b1, ready3 = 1'b1;

  logic             v1, l1, lr1, nf1, t1, busy1;
  logic [DW-1:0]    d1;
  logic [IW-1:0]    b1;
  fnn_state_e       s1;
  logic             v3, l3, lr3, nf3, t3, busy3;
  logic [3*DW-1:0]  d3;
  logic [IW-1:0]    b3;
  fnn_state_e       s3;

  fnn_layer_collector #(.DATA_W(DW), .NUM_NEURONS(NN), .LANES(1), .IDX_W(IW)) dut1 (
    .clk(clk), .rstn(rstn), .start(start), .restart(restart),
    .neuron_done(neuron_done), .neuron_data(neuron_data), .weights_loaded(weights_loaded),
    .out_valid(v1), .out_ready(ready1), .out_data(d1), .out_beat(b1), .out_last(l1),
    .layer_ready(lr1), .neurons_finished(nf1), .transferred(t1), .busy(busy1), .state_dbg(s1));

  fnn_layer_collector #(.DATA_W(DW), .NUM_NEURONS(NN), .LANES(3), .IDX_W(IW)) dut3 (
    .clk(clk), .rstn(rstn), .start(start), .restart(restart),
    .neuron_done(neuron_done), .neuron_data(neuron_data), .weights_loaded(weights_loaded),
    .out_valid(v3), .out_ready(ready3), .out_data(d3), .out_beat(b3), .out_last(l3),
    .layer_ready(lr3), .neurons_finished(nf3), .transferred(t3), .busy(busy3), .state_dbg(s3));

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [W1-1:0] exp_q1[$];
  logic [W3-1:0] exp_q3[$];
  logic [DW-1:0] res[NN];
  int ready_mode = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: value stored for one neuron result.
  function automatic logic [DW-1:0] model_store(input logic [DW-1:0] v);
`ifdef FNN_LAYER_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Reference: split the captured results into beats of 1 and 3 lanes.
  task automatic push_expected();
    logic [3*DW-1:0] d;
    int n;
    for (int b = 0; b < NN; b++)
      exp_q1.push_back({(b == NN - 1), IW'(b), model_store(res[b])});
    for (int b = 0; b < (NN + 2) / 3; b++) begin
      d = '0;
      for (int k = 0; k < 3; k++) begin
        n = b * 3 + k;
        if (n < NN) d[k*DW +: DW] = model_store(res[n]);
      end
      exp_q3.push_back({(b == (NN + 2) / 3 - 1), IW'(b), d});
    end
  endtask

  // ---------------- ready drivers ----------------
  initial begin
    int phase = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: begin ready1 = 1'b1; ready3 = 1'b1; end
        1: begin ready1 = (phase == 0); ready3 = (phase == 0); end
        default: begin
          ready1 = 1'($urandom_range(0, 1));
          ready3 = 1'($urandom_range(0, 1));
        end
      endcase
      phase = (phase + 1) % 3;
    end
  end

  // ---------------- monitors ----------------
  logic          stall1 = 1'b0, stall3 = 1'b0;
  logic [W1-1:0] stall_val1 = '0;
  logic [W3-1:0] stall_val3 = '0;

  always @(negedge clk) begin
    if (!rstn) begin
      stall1 <= 1'b0;
    end else begin
      if (stall1 && v1) check("stall_hold_l1", {l1, b1, d1}, stall_val1);
      if (v1 && ready1) begin
        if (exp_q1.size() == 0) begin
          tests++; fails++;
          $display("FAIL beat_l1: got unexpected beat %0h expected none", {l1, b1, d1});
        end else check("beat_l1", {l1, b1, d1}, exp_q1.pop_front());
      end
      stall1     <= v1 && !ready1;
      stall_val1 <= {l1, b1, d1};
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      stall3 <= 1'b0;
    end else begin
      if (stall3 && v3) check("stall_hold_l3", {l3, b3, d3}, stall_val3);
      if (v3 && ready3) begin
        if (exp_q3.size() == 0) begin
          tests++; fails++;
          $display("FAIL beat_l3: got unexpected beat %0h expected none", {l3, b3, d3});
        end else check("beat_l3", {l3, b3, d3}, exp_q3.pop_front());
      end
      stall3     <= v3 && !ready3;
      stall_val3 <= {l3, b3, d3};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic drive_data();
    for (int i = 0; i < NN; i++) neuron_data[i*DW +: DW] = res[i];
  endtask

  task automatic rand_results();
    for (int i = 0; i < NN; i++) res[i] = DW'($urandom);
  endtask

  // Start a pass, let neurons finish partially then fully; returns right
  // after the capture edge.
  task automatic begin_pass(input bit directed);
    pulse_start();
    check("wait_busy", {busy1, busy3}, 2'b11);
    check("wait_state", s1, WAIT);
    rand_results();
    if (directed) begin
      res[2] = 29'h1FFFFFFF;
      res[5] = 29'h00000010;
    end
    neuron_done = NN'($urandom) & ~NN'(1);
    neuron_data = {NN{29'h0ABCDEF}};
    repeat (2) tick();
    check("no_early_capture", {nf1, nf3, v1}, 3'b000);
    drive_data();
    neuron_done = '1;
    push_expected();
    tick();
    check("first_beat_latency", {v1, v3, nf1, nf3}, 4'b1111);
    // Later neuron changes must not disturb the held results.
    rand_results();
    drive_data();
    neuron_done = '0;
  endtask

  task automatic wait_transfer(input int budget);
    int n = 0;
    while (!(t1 && t3) && n < budget) begin
      tick();
      n++;
    end
    check("transfer_timeout", {t1, t3}, 2'b11);
  endtask

  task automatic finish_pass();
    check("done_flags", {t1, t3, nf1, nf3, busy1, busy3, v1, v3}, 8'b1111_0000);
    check("queue_drained", exp_q1.size() + exp_q3.size(), 0);
    pulse_start();
    check("start_ignored_done", s1, DONE);
    pulse_restart();
    check("restart_to_idle", {s1, s3, t1, nf1}, {IDLE, IDLE, 2'b00});
  endtask

  task automatic run_pass(input int mode, input bit directed);
    ready_mode = mode;
    tick();
    begin_pass(directed);
    if (mode == 0) begin
      repeat (3) tick();
      check("l3_not_done_early", t3, 1'b0);
      tick();
      check("l3_done_4_beats", t3, 1'b1);
      repeat (5) tick();
      check("l1_not_done_early", t1, 1'b0);
      tick();
      check("l1_done_10_beats", t1, 1'b1);
    end else begin
      wait_transfer(300);
    end
    finish_pass();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    weights_loaded = '1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_l1", {v1, d1, b1, l1, lr1, nf1, t1, busy1}, '0);
    check("reset_outputs_l3", {v3, d3, b3, l3, lr3, nf3, t3, busy3}, '0);
    check("reset_state", s1, IDLE);
    rstn = 1'b1;
    weights_loaded = '0;
    tick();

    // Weight flags one at a time: readiness only after the last one.
    for (int i = 0; i < NN; i++) begin
      weights_loaded[i] = 1'b1;
      tick();
      check("layer_ready", {lr1, lr3}, (i == NN - 1) ? 2'b11 : 2'b00);
    end

    run_pass(0, 1'b0);
    run_pass(1, 1'b0);
    run_pass(2, 1'b1);

    // Abort after beat 4 of the single-lane stream has been accepted.
    ready_mode = 0;
    tick();
    begin_pass(1'b0);
    repeat (5) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("abort_outputs", {v1, t1, busy1, nf1}, 4'b0000);
    check("abort_state", s1, IDLE);
    exp_q1.delete();
    exp_q3.delete();
    tick();
    check("abort_stays_idle", {v1, t1}, 2'b00);

    // Fresh pass after abort starts again from beat 0.
    run_pass(0, 1'b0);

    // start and restart together in IDLE: restart wins.
    start = 1'b1;
    restart = 1'b1;
    tick();
    start = 1'b0;
    restart = 1'b0;
    check("restart_beats_start", {busy1, busy3}, 2'b00);

    // Asynchronous reset in the middle of streaming.
    ready_mode = 1;
    tick();
    begin_pass(1'b0);
    repeat (2) tick();
    #2;
    rstn = 1'b0;
    #1;
    check("midreset_l1", {v1, d1, b1, l1, lr1, nf1, t1, busy1}, '0);
    check("midreset_l3", {v3, d3, b3, l3, lr3, nf3, t3, busy3}, '0);
    exp_q1.delete();
    exp_q3.delete();
    @(posedge clk);
    #2;
    rstn = 1'b1;

    run_pass(2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
